// File: rtl/multicycle_datapath.sv
// Register-transfer datapath for the multicycle RV32I core: PC/OldPC/IR/MDR/ALUOut,
// 32x32 register file, immediate extender, ALU and result/address muxing.
module multicycle_datapath #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pcwrite,
    input  logic        adrsource,
    input  logic        memwrite,
    input  logic        irwrite,
    input  logic        regwrite,
    input  logic [1:0]  imm_source,
    input  logic [1:0]  alu_source_a,
    input  logic [1:0]  alu_source_b,
    input  logic [2:0]  alu_control,
    input  logic [1:0]  resultsource,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic        func7_bit5,
    output logic        zero
);
    logic [31:0]       pc, old_pc, ir, data_reg, alu_out;
    logic [31:0][31:0] rf;
    logic [31:0]       rd1, rd2, imm_ext, src_a, src_b, alu_result, result;

    assign opcode     = ir[6:0];
    assign funct3     = ir[14:12];
    assign func7_bit5 = ir[30];

    // Reads are combinational off IR, so they see the pre-write value on a write edge.
    assign rd1 = (ir[19:15] == 5'd0) ? 32'd0 : rf[ir[19:15]];
    assign rd2 = (ir[24:20] == 5'd0) ? 32'd0 : rf[ir[24:20]];

    always_comb begin
        imm_ext = 32'd0;
        case (imm_source)
            2'b00: imm_ext = {{20{ir[31]}}, ir[31:20]};
            2'b01: imm_ext = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            2'b10: imm_ext = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            2'b11: imm_ext = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default: imm_ext = 32'd0;
        endcase
    end

    always_comb begin
        src_a = 32'd0;
        case (alu_source_a)
            2'b00: src_a = pc;
            2'b01: src_a = old_pc;
            2'b10: src_a = rd1;
            default: src_a = 32'd0;
        endcase
    end

    always_comb begin
        src_b = 32'd0;
        case (alu_source_b)
            2'b00: src_b = rd2;
            2'b01: src_b = imm_ext;
            2'b10: src_b = 32'd4;
            default: src_b = 32'd0;
        endcase
    end

    always_comb begin
        alu_result = 32'd0;
        case (alu_control)
            3'b000: alu_result = src_a & src_b;
            3'b001: alu_result = src_a | src_b;
            3'b010: alu_result = src_a + src_b;
            3'b110: alu_result = src_a - src_b;
            3'b111: alu_result = {31'd0, $signed(src_a) < $signed(src_b)};
            default: alu_result = 32'd0;
        endcase
    end

    assign zero = (alu_result == 32'd0);

    always_comb begin
        result = 32'd0;
        case (resultsource)
            2'b00: result = alu_result;
            2'b01: result = data_reg;
            2'b10: result = alu_out;
            default: result = 32'd0;
        endcase
    end

    assign mem_addr  = adrsource ? result : pc;
    assign mem_wdata = rd2;
    assign mem_we    = memwrite;

    // Reset wins over every enable, so no write lands on a reset edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_PC;
            old_pc   <= 32'd0;
            ir       <= 32'd0;
            data_reg <= 32'd0;
            alu_out  <= 32'd0;
            rf       <= '0;
        end else begin
            alu_out  <= alu_result;
            data_reg <= mem_rdata;
            if (pcwrite)
                pc <= result;
            if (irwrite) begin
                ir     <= mem_rdata;
                old_pc <= pc;
            end
            if (regwrite && ir[11:7] != 5'd0)
                rf[ir[11:7]] <= result;
        end
    end
endmodule
